key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 115 +++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, per-key debounce, registered press/release pulses.
// Define KEY_AUTOREPEAT_EN to add per-key auto-repeat pulses on key_press while a key is held.
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keysn_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] r_level;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [DB_W-1:0]   r_db_cnt [N_KEYS];

    logic [N_KEYS-1:0] w_pressed;
    logic [N_KEYS-1:0] w_toggle;
    logic [N_KEYS-1:0] w_press_edge;
    logic [N_KEYS-1:0] w_release_edge;
    logic [N_KEYS-1:0] w_repeat;

    assign w_pressed = ~r_sync2;

    // A toggle fires on the DEBOUNCE_CYCLES-th consecutive mismatch cycle.
    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_toggle[i] = (w_pressed[i] != r_level[i]) && (r_db_cnt[i] == DB_LAST);
        end
    end

    assign w_press_edge   = w_toggle & w_pressed;
    assign w_release_edge = w_toggle & ~w_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= keysn_in;
            r_sync2   <= r_sync1;
            r_level   <= r_level ^ w_toggle;
            r_press   <= w_press_edge | w_repeat;
            r_release <= w_release_edge;
            for (int i = 0; i < N_KEYS; i++) begin
                if ((w_pressed[i] == r_level[i]) || w_toggle[i]) begin
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W     = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rpt_cnt [N_KEYS];

    // A release due in the same cycle wins over the repeat.
    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            w_repeat[i] = r_level[i] && !w_toggle[i] && (r_rpt_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (w_press_edge[i]) begin
                    r_rpt_cnt[i] <= RPT_FIRST;
                end else if (!r_level[i] || w_toggle[i]) begin
                    r_rpt_cnt[i] <= '0;
                end else if (r_rpt_cnt[i] == '0) begin
                    r_rpt_cnt[i] <= RPT_NEXT;
                end else begin
                    r_rpt_cnt[i] <= r_rpt_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign w_repeat = '0;
`endif

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule
